// File: rtl/cpu_pkg.sv
// ============================================================================
// Module      : cpu_pkg
// Description : Control-bus encodings shared by cpu_control and the datapath.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cpu_pkg;

    typedef enum logic [0:0] {PcNextSame, PcNextIncOut} pc_next_e;

    // Order matches the 3-bit r field of the opcode; RegSelF sits in slot 6.
    typedef enum logic [3:0] {
        RegSelB, RegSelC, RegSelD, RegSelE, RegSelH, RegSelL, RegSelF, RegSelA,
        RegSelZ, RegSelW, RegSelPCHi, RegSelPCLo, RegSelSPHi, RegSelSPLo
    } reg_sel_e;

    typedef enum logic [1:0] {RegOpNone, RegOpWriteAlu, RegOpWriteMem} reg_op_e;
    typedef enum logic [1:0] {IncOpNone, IncOpInc, IncOpDec} inc_op_e;
    typedef enum logic [2:0] {
        IncRegPC, IncRegHL, IncRegWZ, IncRegInst16, IncRegPC_ALU
    } inc_reg_e;
    typedef enum logic [1:0] {AluOpCopyA, AluOpInstAlu, AluOpAddLo, AluOpAddHi} alu_op_e;
    typedef enum logic [0:0] {AluSelAReg1, AluSelARegA} alu_sel_a_e;
    typedef enum logic [0:0] {AluSelBReg2, AluSelBSignReg2} alu_sel_b_e;
    typedef enum logic [0:0] {AluFlagSetNone, AluFlagSetAll} alu_flag_set_e;
    typedef enum logic [0:0] {MemAddrSelIncrementer, MemAddrSelHigh} mem_addr_sel_e;

    localparam int unsigned c_STEP_W = 3;
    // Step at which a JR sequence fetches; a failed condition jumps straight here.
    localparam logic [c_STEP_W-1:0] c_STEP_JR_FETCH = 3'd3;

    typedef struct packed {
        pc_next_e      pc_next;
        logic          inst_load;
        reg_sel_e      reg_read1_sel;
        reg_sel_e      reg_read2_sel;
        reg_sel_e      reg_write_sel;
        reg_op_e       reg_op;
        inc_op_e       inc_op;
        inc_reg_e      inc_reg;
        alu_op_e       alu_op;
        alu_sel_a_e    alu_sel_a;
        alu_sel_b_e    alu_sel_b;
        alu_flag_set_e alu_flag_set;
        logic          mem_enable;
        logic          mem_write;
        mem_addr_sel_e mem_addr_sel;
    } ctrl_t;

    localparam ctrl_t c_CTRL_DEFAULT = '{
        pc_next:       PcNextSame,
        inst_load:     1'b0,
        reg_read1_sel: RegSelB,
        reg_read2_sel: RegSelB,
        reg_write_sel: RegSelB,
        reg_op:        RegOpNone,
        inc_op:        IncOpNone,
        inc_reg:       IncRegPC,
        alu_op:        AluOpCopyA,
        alu_sel_a:     AluSelAReg1,
        alu_sel_b:     AluSelBReg2,
        alu_flag_set:  AluFlagSetNone,
        mem_enable:    1'b0,
        mem_write:     1'b0,
        mem_addr_sel:  MemAddrSelIncrementer
    };

    function automatic reg_sel_e reg8_sel(input logic [2:0] f);
        return reg_sel_e'({1'b0, f});
    endfunction

    function automatic reg_sel_e reg16_lo(input logic [1:0] rr);
        case (rr)
            2'd0:    return RegSelC;
            2'd1:    return RegSelE;
            2'd2:    return RegSelL;
            default: return RegSelSPLo;
        endcase
    endfunction

    function automatic reg_sel_e reg16_hi(input logic [1:0] rr);
        case (rr)
            2'd0:    return RegSelB;
            2'd1:    return RegSelD;
            2'd2:    return RegSelH;
            default: return RegSelSPHi;
        endcase
    endfunction

    function automatic ctrl_t ctrl_fetch();
        ctrl_t c = c_CTRL_DEFAULT;
        c.mem_enable = 1'b1;
        c.inc_reg    = IncRegPC;
        c.inc_op     = IncOpInc;
        c.pc_next    = PcNextIncOut;
        c.inst_load  = 1'b1;
        return c;
    endfunction

    function automatic ctrl_t ctrl_read_imm(input reg_sel_e dst);
        ctrl_t c = c_CTRL_DEFAULT;
        c.mem_enable    = 1'b1;
        c.inc_reg       = IncRegPC;
        c.inc_op        = IncOpInc;
        c.pc_next       = PcNextIncOut;
        c.reg_op        = RegOpWriteMem;
        c.reg_write_sel = dst;
        return c;
    endfunction

    function automatic ctrl_t ctrl_read_hl(input reg_sel_e dst, input inc_op_e op);
        ctrl_t c = c_CTRL_DEFAULT;
        c.mem_enable    = 1'b1;
        c.inc_reg       = IncRegHL;
        c.inc_op        = op;
        c.reg_op        = RegOpWriteMem;
        c.reg_write_sel = dst;
        return c;
    endfunction

    function automatic ctrl_t ctrl_write_hl(input alu_sel_a_e src, input inc_op_e op);
        ctrl_t c = c_CTRL_DEFAULT;
        c.mem_enable = 1'b1;
        c.mem_write  = 1'b1;
        c.inc_reg    = IncRegHL;
        c.inc_op     = op;
        c.alu_op     = AluOpCopyA;
        c.alu_sel_a  = src;
        return c;
    endfunction

    // Opcode fetch overlapped with the accumulator ALU operation; CP keeps A.
    function automatic ctrl_t ctrl_alu_fetch(input reg_sel_e rhs, input logic [2:0] ooo);
        ctrl_t c = ctrl_fetch();
        c.alu_op        = AluOpInstAlu;
        c.alu_sel_a     = AluSelARegA;
        c.reg_read2_sel = rhs;
        c.alu_flag_set  = AluFlagSetAll;
        if (ooo != 3'd7) begin
            c.reg_op        = RegOpWriteAlu;
            c.reg_write_sel = RegSelA;
        end
        return c;
    endfunction

endpackage

`default_nettype wire

// File: rtl/cpu_decode.sv
// ============================================================================
// Module      : cpu_decode
// Description : Maps (opcode, step, condition) to the control word of an M-cycle.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cpu_decode
    import cpu_pkg::*;
(
    input  logic [7:0]          opcode_i,
    input  logic [c_STEP_W-1:0] step_i,
    input  logic                condition_i,
    output ctrl_t               ctrl_o,
    output logic                skip_o
);

    logic [2:0] w_dst;
    logic [2:0] w_src;
    logic [1:0] w_rr;

    assign w_dst = opcode_i[5:3];
    assign w_src = opcode_i[2:0];
    assign w_rr  = opcode_i[5:4];

    // Any step past an instruction's last listed cycle decodes as fetch.
    always_comb begin
        ctrl_o = ctrl_fetch();
        skip_o = 1'b0;
        if (opcode_i[7:6] == 2'b01 && opcode_i != 8'h76) begin
            if (w_src == 3'd6) begin
                if (step_i == '0) ctrl_o = ctrl_read_hl(reg8_sel(w_dst), IncOpNone);
            end else if (w_dst == 3'd6) begin
                if (step_i == '0) begin
                    ctrl_o = ctrl_write_hl(AluSelAReg1, IncOpNone);
                    ctrl_o.reg_read1_sel = reg8_sel(w_src);
                end
            end else begin
                ctrl_o.alu_op        = AluOpCopyA;
                ctrl_o.reg_read1_sel = reg8_sel(w_src);
                ctrl_o.reg_op        = RegOpWriteAlu;
                ctrl_o.reg_write_sel = reg8_sel(w_dst);
            end
        end else if (opcode_i[7:6] == 2'b10 || (opcode_i[7:6] == 2'b11 && w_src == 3'd6)) begin
            if (w_src != 3'd6) begin
                ctrl_o = ctrl_alu_fetch(reg8_sel(w_src), w_dst);
            end else if (step_i == '0) begin
                ctrl_o = opcode_i[6] ? ctrl_read_imm(RegSelZ) : ctrl_read_hl(RegSelZ, IncOpNone);
            end else begin
                ctrl_o = ctrl_alu_fetch(RegSelZ, w_dst);
            end
        end else begin
            case (opcode_i)
                8'h22: if (step_i == '0) ctrl_o = ctrl_write_hl(AluSelARegA, IncOpInc);
                8'h32: if (step_i == '0) ctrl_o = ctrl_write_hl(AluSelARegA, IncOpDec);
                8'h2A: if (step_i == '0) ctrl_o = ctrl_read_hl(RegSelA, IncOpInc);
                8'h3A: if (step_i == '0) ctrl_o = ctrl_read_hl(RegSelA, IncOpDec);
                8'hC3: begin
                    case (step_i)
                        3'd0: ctrl_o = ctrl_read_imm(RegSelZ);
                        3'd1: ctrl_o = ctrl_read_imm(RegSelW);
                        3'd2: begin
                            ctrl_o         = c_CTRL_DEFAULT;
                            ctrl_o.inc_reg = IncRegWZ;
                            ctrl_o.pc_next = PcNextIncOut;
                        end
                        default: ;
                    endcase
                end
                8'h18, 8'h20, 8'h28, 8'h30, 8'h38: begin
                    case (step_i)
                        3'd0: begin
                            ctrl_o = ctrl_read_imm(RegSelZ);
                            skip_o = (opcode_i != 8'h18) && !condition_i;
                        end
                        3'd1: begin
                            ctrl_o               = c_CTRL_DEFAULT;
                            ctrl_o.alu_op        = AluOpAddLo;
                            ctrl_o.reg_read1_sel = RegSelPCLo;
                            ctrl_o.reg_read2_sel = RegSelZ;
                            ctrl_o.reg_op        = RegOpWriteAlu;
                            ctrl_o.reg_write_sel = RegSelPCLo;
                        end
                        3'd2: begin
                            ctrl_o               = c_CTRL_DEFAULT;
                            ctrl_o.alu_op        = AluOpAddHi;
                            ctrl_o.reg_read1_sel = RegSelPCHi;
                            ctrl_o.alu_sel_b     = AluSelBSignReg2;
                            ctrl_o.reg_read2_sel = RegSelZ;
                            ctrl_o.inc_reg       = IncRegPC_ALU;
                            ctrl_o.pc_next       = PcNextIncOut;
                        end
                        default: ;
                    endcase
                end
                8'hE0, 8'hF0, 8'hE2, 8'hF2: begin
                    if (!opcode_i[1] && step_i == '0) begin
                        ctrl_o = ctrl_read_imm(RegSelZ);
                    end else if (step_i == (opcode_i[1] ? 3'd0 : 3'd1)) begin
                        ctrl_o = opcode_i[4] ? ctrl_read_hl(RegSelA, IncOpNone)
                                             : ctrl_write_hl(AluSelARegA, IncOpNone);
                        ctrl_o.inc_reg       = IncRegPC;
                        ctrl_o.mem_addr_sel  = MemAddrSelHigh;
                        ctrl_o.reg_read2_sel = opcode_i[1] ? RegSelC : RegSelZ;
                    end
                end
                default: begin
                    if (opcode_i[7:6] == 2'b00 && w_src == 3'd6 && w_dst != 3'd6) begin
                        if (step_i == '0) ctrl_o = ctrl_read_imm(reg8_sel(w_dst));
                    end else if (opcode_i[7:6] == 2'b00 && opcode_i[3:0] == 4'h1) begin
                        if (step_i == 3'd0) ctrl_o = ctrl_read_imm(reg16_lo(w_rr));
                        else if (step_i == 3'd1) ctrl_o = ctrl_read_imm(reg16_hi(w_rr));
                    end else if (opcode_i[7:6] == 2'b00 && opcode_i[2:0] == 3'b011) begin
                        if (step_i == '0) begin
                            ctrl_o         = c_CTRL_DEFAULT;
                            ctrl_o.inc_reg = IncRegInst16;
                            ctrl_o.inc_op  = opcode_i[3] ? IncOpDec : IncOpInc;
                        end
                    end
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/cpu_control.sv
// ============================================================================
// Module      : cpu_control
// Description : Opcode register and M-cycle step counter driving the decoder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cpu_control
    import cpu_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    input  logic [1:0]    t_cycle,
    input  logic [7:0]    mem_data_in,
    input  logic          condition,
    output pc_next_e      pc_next,
    output logic          inst_load,
    output reg_sel_e      reg_read1_sel,
    output reg_sel_e      reg_read2_sel,
    output reg_sel_e      reg_write_sel,
    output reg_op_e       reg_op,
    output inc_op_e       inc_op,
    output inc_reg_e      inc_reg,
    output alu_op_e       alu_op,
    output alu_sel_a_e    alu_sel_a,
    output alu_sel_b_e    alu_sel_b,
    output alu_flag_set_e alu_flag_set,
    output logic          mem_enable,
    output logic          mem_write,
    output mem_addr_sel_e mem_addr_sel
);

    logic [7:0]          opcode_q, opcode_d;
    logic [c_STEP_W-1:0] step_q, step_d;
    ctrl_t               w_ctrl;
    logic                w_skip;

    always_ff @(posedge clk) begin
        if (reset) begin
            opcode_q <= 8'h00;
            step_q   <= '0;
        end else begin
            opcode_q <= opcode_d;
            step_q   <= step_d;
        end
    end

    always_comb begin
        opcode_d = opcode_q;
        step_d   = step_q;
        if (t_cycle == 2'd3) begin
            if (w_ctrl.inst_load) begin
                opcode_d = mem_data_in;
                step_d   = '0;
            end else if (w_skip) begin
                step_d = c_STEP_JR_FETCH;
            end else begin
                step_d = step_q + c_STEP_W'(1);
            end
        end
    end

    cpu_decode u_decode (
        .opcode_i    (opcode_q),
        .step_i      (step_q),
        .condition_i (condition),
        .ctrl_o      (w_ctrl),
        .skip_o      (w_skip)
    );

    assign pc_next       = w_ctrl.pc_next;
    assign inst_load     = w_ctrl.inst_load;
    assign reg_read1_sel = w_ctrl.reg_read1_sel;
    assign reg_read2_sel = w_ctrl.reg_read2_sel;
    assign reg_write_sel = w_ctrl.reg_write_sel;
    assign reg_op        = w_ctrl.reg_op;
    assign inc_op        = w_ctrl.inc_op;
    assign inc_reg       = w_ctrl.inc_reg;
    assign alu_op        = w_ctrl.alu_op;
    assign alu_sel_a     = w_ctrl.alu_sel_a;
    assign alu_sel_b     = w_ctrl.alu_sel_b;
    assign alu_flag_set  = w_ctrl.alu_flag_set;
    assign mem_enable    = w_ctrl.mem_enable;
    assign mem_write     = w_ctrl.mem_write;
    assign mem_addr_sel  = w_ctrl.mem_addr_sel;

endmodule

`default_nettype wire

// File: tb/tb_cpu_control.sv
// ============================================================================
// Module      : tb_cpu_control
// Description : Directed instruction sequences with hand-computed control words.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_cpu_control;
    import cpu_pkg::*;

    logic          clk = 1'b0;
    logic          reset;
    logic [1:0]    t_cycle;
    logic [7:0]    mem_data_in;
    logic          condition;
    pc_next_e      pc_next;
    logic          inst_load;
    reg_sel_e      reg_read1_sel, reg_read2_sel, reg_write_sel;
    reg_op_e       reg_op;
    inc_op_e       inc_op;
    inc_reg_e      inc_reg;
    alu_op_e       alu_op;
    alu_sel_a_e    alu_sel_a;
    alu_sel_b_e    alu_sel_b;
    alu_flag_set_e alu_flag_set;
    logic          mem_enable, mem_write;
    mem_addr_sel_e mem_addr_sel;

    int n_total = 0;
    int n_bad   = 0;

    always #125 clk = ~clk;

    cpu_control dut (
        .clk           (clk),
        .reset         (reset),
        .t_cycle       (t_cycle),
        .mem_data_in   (mem_data_in),
        .condition     (condition),
        .pc_next       (pc_next),
        .inst_load     (inst_load),
        .reg_read1_sel (reg_read1_sel),
        .reg_read2_sel (reg_read2_sel),
        .reg_write_sel (reg_write_sel),
        .reg_op        (reg_op),
        .inc_op        (inc_op),
        .inc_reg       (inc_reg),
        .alu_op        (alu_op),
        .alu_sel_a     (alu_sel_a),
        .alu_sel_b     (alu_sel_b),
        .alu_flag_set  (alu_flag_set),
        .mem_enable    (mem_enable),
        .mem_write     (mem_write),
        .mem_addr_sel  (mem_addr_sel)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One M-cycle; the bus carries junk until T3 so only the T3 value may be latched.
    task automatic run_mcycle(input logic [7:0] bus, input logic cond);
        condition = cond;
        for (int t = 0; t < 4; t++) begin
            t_cycle     = t[1:0];
            mem_data_in = (t == 3) ? bus : ~bus;
            @(posedge clk);
            #1;
        end
        t_cycle = 2'd0;
    endtask

    task automatic check_fetch(input string tag);
        check_eq({tag, ".inst_load"}, inst_load, 1'b1);
        check_eq({tag, ".pc_next"}, pc_next, PcNextIncOut);
        check_eq({tag, ".mem_en"}, mem_enable, 1'b1);
        check_eq({tag, ".inc_op"}, inc_op, IncOpInc);
        check_eq({tag, ".inc_reg"}, inc_reg, IncRegPC);
        check_eq({tag, ".mem_wr"}, mem_write, 1'b0);
    endtask

    task automatic check_ri(input string tag, input reg_sel_e dst);
        check_eq({tag, ".inst_load"}, inst_load, 1'b0);
        check_eq({tag, ".mem_en"}, mem_enable, 1'b1);
        check_eq({tag, ".pc_next"}, pc_next, PcNextIncOut);
        check_eq({tag, ".reg_op"}, reg_op, RegOpWriteMem);
        check_eq({tag, ".wsel"}, reg_write_sel, dst);
    endtask

    initial begin
        reset = 1'b1; t_cycle = 2'd0; mem_data_in = 8'h00; condition = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        check_fetch("rst");
        check_eq("rst.reg_op", reg_op, RegOpNone);
        check_eq("rst.alu_op", alu_op, AluOpCopyA);
        check_eq("rst.addr", mem_addr_sel, MemAddrSelIncrementer);
        run_mcycle(8'h00, 1'b0); check_fetch("nop1");
        run_mcycle(8'h00, 1'b0); check_fetch("nop2");

        // LD A,n
        run_mcycle(8'h3E, 1'b0); check_ri("ldan.s0", RegSelA);
        check_eq("ldan.inc_op", inc_op, IncOpInc);
        run_mcycle(8'h42, 1'b0); check_fetch("ldan.s1");

        // JR NZ,e not taken
        run_mcycle(8'h20, 1'b0); check_ri("jrn.s0", RegSelZ);
        run_mcycle(8'h05, 1'b0); check_fetch("jrn.s1");

        // JR NZ,e taken; later cycles must ignore condition
        run_mcycle(8'h20, 1'b0); check_ri("jrt.s0", RegSelZ);
        run_mcycle(8'h05, 1'b1);
        check_eq("jrt.s1.alu", alu_op, AluOpAddLo);
        check_eq("jrt.s1.r1", reg_read1_sel, RegSelPCLo);
        check_eq("jrt.s1.r2", reg_read2_sel, RegSelZ);
        check_eq("jrt.s1.op", reg_op, RegOpWriteAlu);
        check_eq("jrt.s1.w", reg_write_sel, RegSelPCLo);
        check_eq("jrt.s1.men", mem_enable, 1'b0);
        check_eq("jrt.s1.il", inst_load, 1'b0);
        run_mcycle(8'h00, 1'b0);
        check_eq("jrt.s2.alu", alu_op, AluOpAddHi);
        check_eq("jrt.s2.r1", reg_read1_sel, RegSelPCHi);
        check_eq("jrt.s2.selb", alu_sel_b, AluSelBSignReg2);
        check_eq("jrt.s2.inc_reg", inc_reg, IncRegPC_ALU);
        check_eq("jrt.s2.inc_op", inc_op, IncOpNone);
        check_eq("jrt.s2.pcn", pc_next, PcNextIncOut);
        check_eq("jrt.s2.op", reg_op, RegOpNone);
        run_mcycle(8'h00, 1'b0); check_fetch("jrt.s3");

        // JP nn
        run_mcycle(8'hC3, 1'b0); check_ri("jp.s0", RegSelZ);
        run_mcycle(8'h00, 1'b0); check_ri("jp.s1", RegSelW);
        run_mcycle(8'h10, 1'b0);
        check_eq("jp.s2.inc_reg", inc_reg, IncRegWZ);
        check_eq("jp.s2.inc_op", inc_op, IncOpNone);
        check_eq("jp.s2.pcn", pc_next, PcNextIncOut);
        check_eq("jp.s2.men", mem_enable, 1'b0);
        check_eq("jp.s2.il", inst_load, 1'b0);
        run_mcycle(8'h00, 1'b0); check_fetch("jp.s3");

        // CP n
        run_mcycle(8'hFE, 1'b0); check_ri("cp.s0", RegSelZ);
        run_mcycle(8'h10, 1'b0); check_fetch("cp.s1");
        check_eq("cp.alu", alu_op, AluOpInstAlu);
        check_eq("cp.flag", alu_flag_set, AluFlagSetAll);
        check_eq("cp.op", reg_op, RegOpNone);
        check_eq("cp.sela", alu_sel_a, AluSelARegA);
        check_eq("cp.r2", reg_read2_sel, RegSelZ);

        // LDH (n),A
        run_mcycle(8'hE0, 1'b0); check_ri("ldh.s0", RegSelZ);
        run_mcycle(8'h80, 1'b0);
        check_eq("ldh.s1.wr", mem_write, 1'b1);
        check_eq("ldh.s1.men", mem_enable, 1'b1);
        check_eq("ldh.s1.addr", mem_addr_sel, MemAddrSelHigh);
        check_eq("ldh.s1.r2", reg_read2_sel, RegSelZ);
        check_eq("ldh.s1.sela", alu_sel_a, AluSelARegA);
        check_eq("ldh.s1.il", inst_load, 1'b0);
        run_mcycle(8'h00, 1'b0); check_fetch("ldh.s2");

        // ADD A,B then LD B,C (single-cycle, fetch overlapped)
        run_mcycle(8'h80, 1'b0); check_fetch("add");
        check_eq("add.alu", alu_op, AluOpInstAlu);
        check_eq("add.r2", reg_read2_sel, RegSelB);
        check_eq("add.op", reg_op, RegOpWriteAlu);
        check_eq("add.w", reg_write_sel, RegSelA);
        run_mcycle(8'h41, 1'b0); check_fetch("ldbc");
        check_eq("ldbc.r1", reg_read1_sel, RegSelC);
        check_eq("ldbc.w", reg_write_sel, RegSelB);
        check_eq("ldbc.op", reg_op, RegOpWriteAlu);

        // INC BC
        run_mcycle(8'h03, 1'b0);
        check_eq("incbc.inc_reg", inc_reg, IncRegInst16);
        check_eq("incbc.inc_op", inc_op, IncOpInc);
        check_eq("incbc.men", mem_enable, 1'b0);
        check_eq("incbc.il", inst_load, 1'b0);
        run_mcycle(8'h00, 1'b0); check_fetch("incbc.s1");

        // Reset in the middle of JP aborts it
        run_mcycle(8'hC3, 1'b0); check_ri("abort.s0", RegSelZ);
        t_cycle = 2'd1; reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0; t_cycle = 2'd0;
        check_fetch("abort.rst");
        run_mcycle(8'h00, 1'b0); check_fetch("abort.nop");

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: got=running exp=finished");
        $fatal(1);
    end

endmodule

`default_nettype wire

// File: doc/cpu_control.md
CPU_CONTROL -- requirements
Module: cpu_control

Interface
REQ-001 No parameters; one clock; reset is synchronous and active-high.
REQ-002 clk  in  1  system clock, 4 MHz nominal; all state updates on the rising edge.
REQ-003 reset  in  1  synchronous, active-high.
REQ-004 t_cycle  in  2  T-cycle index within the M-cycle; 3 is the last T-cycle.
REQ-005 mem_data_in  in  8  system-bus read data.
REQ-006 condition  in  1  jump-condition result for opcode bits 4:3 (NZ/Z/NC/C), combinational from the datapath.
REQ-007 pc_next  out  pc_next_e  PC update select.
REQ-008 inst_load  out  1  this M-cycle fetches the next opcode.
REQ-009 reg_read1_sel, reg_read2_sel, reg_write_sel  out  reg_sel_e each  register-port selects.
REQ-010 reg_op  out  reg_op_e  register-write source (none/ALU/memory).
REQ-011 inc_op  out  inc_op_e; inc_reg  out  inc_reg_e  16-bit incrementer control.
REQ-012 alu_op  out  alu_op_e; alu_sel_a  out  alu_sel_a_e; alu_sel_b  out  alu_sel_b_e; alu_flag_set  out  alu_flag_set_e  ALU control.
REQ-013 mem_enable  out  1; mem_write  out  1; mem_addr_sel  out  mem_addr_sel_e  bus control.

Function
REQ-014 State: 8-bit opcode register and an M-cycle step counter; both update only when t_cycle==3.
REQ-015 All outputs are combinational from (opcode, step, condition) and SHALL stay constant for the whole M-cycle.
REQ-016 When inst_load==1 at t_cycle==3: opcode <= mem_data_in and step <= 0; otherwise step <= step+1.
REQ-017 Default output in every cycle: PcNextSame, RegOpNone, IncOpNone, IncRegPC, AluOpCopyA, AluSelAReg1, AluSelBReg2, AluFlagSetNone, MemAddrSelIncrementer, all enables 0.
REQ-018 Fetch cycle F: mem_enable=1, IncRegPC, IncOpInc, PcNextIncOut, inst_load=1.
REQ-019 Read-immediate cycle RI(x): mem_enable=1, IncRegPC, IncOpInc, PcNextIncOut, RegOpWriteMem to x.
REQ-020 Store cycles use mem_write=1; write data is ALU CopyA, from A (AluSelARegA) or from the register on read port 1 (AluSelAReg1).
REQ-021 NOP 00 and every unlisted opcode: F.
REQ-022 LD r,r' (40-7F, neither operand (HL); 76 excluded): F plus ALU CopyA from read1=Reg8Src, WriteAlu to Reg8Dest.
REQ-023 LD r,n (00rrr110, r≠6): RI(Reg8Dest); F.
REQ-024 LD r,(HL): read at IncRegHL, WriteMem to Reg8Dest; F.
REQ-025 LD (HL),r: write at IncRegHL from Reg8Src; F.
REQ-026 ALU A,r (10ooorrr, r≠6): F plus AluOpInstAlu, AluSelARegA, read2=Reg8Src, AluFlagSetAll, WriteAlu to A; CP (ooo=111) writes no register.
REQ-027 ALU A,(HL) and ALU A,n (11ooo110): first read HL (IncOpNone) or RI, into Z; then F plus the ALU operation with read2=Z.
REQ-028 LD rr,nn (00rr0001): RI(Reg16Lo); RI(Reg16Hi); F.
REQ-029 INC/DEC rr (00rr0011/00rr1011): IncRegInst16 with IncOpInc/IncOpDec, no bus access; F.
REQ-030 22/32 LD (HL+/-),A: write A at HL with HL inc/dec; F. 2A/3A LD A,(HL+/-): read HL to A with HL inc/dec; F.
REQ-031 JP nn (C3): RI(Z); RI(W); PC<=WZ (IncRegWZ, IncOpNone, PcNextIncOut, no bus); F — 4 M-cycles.
REQ-032 JR e (18) and JR cc,e (20/28/30/38): RI(Z).
  - Condition false at that step's t_cycle==3: F next (2 M-cycles).
  - Otherwise: AluOpAddLo read1=PCLo read2=Z WriteAlu to PCLo; then AluOpAddHi read1=PCHi AluSelBSignReg2 read2=Z, IncRegPC_ALU, IncOpNone, PcNextIncOut; then F (4 M-cycles).
REQ-033 LDH (n),A E0 / LDH A,(n) F0: RI(Z); MemAddrSelHigh with read2=Z, write A / read to A; F.
REQ-034 LDH (C),A E2 / LDH A,(C) F2: MemAddrSelHigh with read2=C, write A / read to A; F.

Reset
REQ-035 reset: opcode <= 00, step <= 0, so the first M-cycle after reset is F at PC 0000; reset mid-instruction aborts it.

Structure
REQ-036 Package cpu_pkg holds every *_e enum, encoded in declaration order from 0; it is shared with the datapath.
REQ-037 Single module; an optional decode sub-module cpu_decode maps (opcode, step, condition) to the output struct.

Verification
REQ-038 Reset, then bus returns 00 per fetch -> F every M-cycle, with inst_load=1 and PcNextIncOut.
REQ-039 3E 42 (LD A,n) -> step0 RI WriteMem to A, step1 F; opcode latched at t_cycle==3.
REQ-040 20 05 with condition=0 -> 2 M-cycles; with condition=1 -> AddLo, AddHi/IncRegPC_ALU, then F.
REQ-041 C3 00 10 -> RI(Z), RI(W), IncRegWZ with PcNextIncOut, then F.
REQ-042 FE 10 (CP n) -> F cycle has AluOpInstAlu, AluFlagSetAll, RegOpNone.
REQ-043 E0 80 -> step1 mem_write=1, MemAddrSelHigh, read2 = Z.
